// File: rtl/snow64_seq_divider_pkg.sv
// Shared definitions for the Snow64 sequential divider: state encoding,
// legal operand widths and the most-negative-value helper.
package snow64_seq_divider_pkg;

   // Legal operand/result widths for the divider.
   localparam int WIDTH_8  = 8;
   localparam int WIDTH_16 = 16;
   localparam int WIDTH_32 = 32;
   localparam int WIDTH_64 = 64;

   // Divider control states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_FIXUP   = 3'd2,
      ST_SPECIAL = 3'd3,
      ST_DONE    = 3'd4
   } div_state_t;

   // Two's-complement most-negative value for a given width, returned in
   // the low bits of a 64-bit word; callers slice to their own width.
   function automatic logic [63:0] min_value(input int width);
      min_value = 64'd1 << (width - 1);
   endfunction

endpackage

// File: rtl/snow64_seq_divider_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract
// the divisor from the widened remainder, and keep or restore.
module snow64_div_step
   import snow64_seq_divider_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] quo_next
);

   // The remainder entering a step is always below the divisor, so its top
   // bit is zero and the shifted value still fits WIDTH+1 bits.
   logic             unused_rem_msb;
   logic [WIDTH:0]   shifted_rem;
   logic [WIDTH:0]   trial;
   logic             trial_ok;

   assign unused_rem_msb = rem[WIDTH];
   assign shifted_rem    = {rem[WIDTH-1:0], quo[WIDTH-1]};
   assign trial          = shifted_rem - {1'b0, divisor};
   // A clear sign bit means the divisor fit into the shifted remainder.
   assign trial_ok       = ~trial[WIDTH];
   assign rem_next       = trial_ok ? trial : shifted_rem;
   assign quo_next       = {quo[WIDTH-2:0], trial_ok};

endmodule

// File: rtl/snow64_seq_divider.sv
// Multi-cycle radix-2 restoring divider with valid/ready on both sides.
// Signed operands are divided as magnitudes and sign-corrected at the end;
// divide-by-zero and MIN / -1 bypass the iteration entirely.
module snow64_seq_divider
   import snow64_seq_divider_pkg::*;
#(
   parameter int WIDTH__DATA_INOUT = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         out_ready,
   input  logic                         in_signed,
   input  logic [WIDTH__DATA_INOUT-1:0] in_dividend,
   input  logic [WIDTH__DATA_INOUT-1:0] in_divisor,
   output logic                         out_valid,
   input  logic                         in_result_ready,
   output logic [WIDTH__DATA_INOUT-1:0] out_quotient,
   output logic [WIDTH__DATA_INOUT-1:0] out_remainder,
   output logic                         out_busy
);

   localparam int W  = WIDTH__DATA_INOUT;
   localparam int CW = $clog2(W) + 1;

   localparam logic [63:0]   MIN_FULL   = min_value(W);
   localparam logic [W-1:0]  MIN_VAL    = MIN_FULL[W-1:0];
   localparam logic [W-1:0]  ALL_ONES   = '1;
   localparam logic [CW-1:0] COUNT_INIT = CW'(W);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

   div_state_t      state_reg;
   logic [CW-1:0]   count_reg;
   logic [W:0]      rem_reg;
   logic [W-1:0]    quo_reg;
   logic [W-1:0]    divisor_reg;
   logic            sign_q_reg;
   logic            sign_r_reg;
   logic            div_zero_reg;

   logic            dividend_neg;
   logic            divisor_neg;
   logic [W-1:0]    dividend_mag;
   logic [W-1:0]    divisor_mag;
   logic            divisor_zero;
   logic            is_special;
   logic [W:0]      rem_next;
   logic [W-1:0]    quo_next;

   // Operand decode at the accept point; the magnitude of MIN is MIN itself,
   // which is exactly the unsigned magnitude wanted.
   assign dividend_neg = in_signed & in_dividend[W-1];
   assign divisor_neg  = in_signed & in_divisor[W-1];
   assign dividend_mag = dividend_neg ? (~in_dividend + 1'b1) : in_dividend;
   assign divisor_mag  = divisor_neg  ? (~in_divisor + 1'b1)  : in_divisor;
   assign divisor_zero = (in_divisor == '0);
   assign is_special   = divisor_zero |
                         (in_signed & (in_dividend == MIN_VAL) & (in_divisor == ALL_ONES));

   snow64_div_step #(
      .WIDTH (W)
   ) u_div_step (
      .rem      (rem_reg),
      .quo      (quo_reg),
      .divisor  (divisor_reg),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // Control FSM, iteration datapath and registered handshake/result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         count_reg     <= '0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         divisor_reg   <= '0;
         sign_q_reg    <= 1'b0;
         sign_r_reg    <= 1'b0;
         div_zero_reg  <= 1'b0;
         out_valid     <= 1'b0;
         out_quotient  <= '0;
         out_remainder <= '0;
         out_busy      <= 1'b0;
         out_ready     <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (in_valid && out_ready) begin
                  sign_q_reg   <= dividend_neg ^ divisor_neg;
                  sign_r_reg   <= dividend_neg;
                  div_zero_reg <= divisor_zero;
                  rem_reg      <= '0;
                  out_ready    <= 1'b0;
                  out_busy     <= 1'b1;
                  if (is_special) begin
                     // Raw dividend is parked in quo_reg: it becomes the
                     // remainder for divide-by-zero.
                     quo_reg   <= in_dividend;
                     state_reg <= ST_SPECIAL;
                  end else begin
                     quo_reg     <= dividend_mag;
                     divisor_reg <= divisor_mag;
                     count_reg   <= COUNT_INIT;
                     state_reg   <= ST_RUN;
                  end
               end
            end

            ST_RUN: begin
               rem_reg   <= rem_next;
               quo_reg   <= quo_next;
               count_reg <= count_reg - COUNT_ONE;
               if (count_reg == COUNT_ONE) begin
                  state_reg <= ST_FIXUP;
               end
            end

            ST_FIXUP: begin
               out_quotient  <= sign_q_reg ? (~quo_reg + 1'b1) : quo_reg;
               out_remainder <= sign_r_reg ? (~rem_reg[W-1:0] + 1'b1) : rem_reg[W-1:0];
               out_valid     <= 1'b1;
               state_reg     <= ST_DONE;
            end

            ST_SPECIAL: begin
               out_quotient  <= div_zero_reg ? ALL_ONES : MIN_VAL;
               out_remainder <= div_zero_reg ? quo_reg : '0;
               out_valid     <= 1'b1;
               state_reg     <= ST_DONE;
            end

            ST_DONE: begin
               if (in_result_ready) begin
                  out_valid <= 1'b0;
                  out_busy  <= 1'b0;
                  out_ready <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
               out_valid <= 1'b0;
               out_busy  <= 1'b0;
               out_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snow64_seq_divider.sv
// Self-checking bench for snow64_seq_divider: a 64-bit instance for the main
// scenarios and an 8-bit instance for the narrow-width boundary cases.
module tb_snow64_seq_divider;

   localparam int W  = 64;
   localparam int W8 = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;

   logic          in_valid = 1'b0;
   logic          out_ready;
   logic          in_signed = 1'b0;
   logic [W-1:0]  in_dividend = '0;
   logic [W-1:0]  in_divisor = '0;
   logic          out_valid;
   logic          in_result_ready = 1'b0;
   logic [W-1:0]  out_quotient;
   logic [W-1:0]  out_remainder;
   logic          out_busy;

   logic          d8_in_valid = 1'b0;
   logic          d8_out_ready;
   logic          d8_in_signed = 1'b0;
   logic [W8-1:0] d8_in_dividend = '0;
   logic [W8-1:0] d8_in_divisor = '0;
   logic          d8_out_valid;
   logic          d8_in_result_ready = 1'b0;
   logic [W8-1:0] d8_out_quotient;
   logic [W8-1:0] d8_out_remainder;
   logic          d8_out_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   snow64_seq_divider #(.WIDTH__DATA_INOUT(W)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .out_ready       (out_ready),
      .in_signed       (in_signed),
      .in_dividend     (in_dividend),
      .in_divisor      (in_divisor),
      .out_valid       (out_valid),
      .in_result_ready (in_result_ready),
      .out_quotient    (out_quotient),
      .out_remainder   (out_remainder),
      .out_busy        (out_busy)
   );

   snow64_seq_divider #(.WIDTH__DATA_INOUT(W8)) u_dut8 (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (d8_in_valid),
      .out_ready       (d8_out_ready),
      .in_signed       (d8_in_signed),
      .in_dividend     (d8_in_dividend),
      .in_divisor      (d8_in_divisor),
      .out_valid       (d8_out_valid),
      .in_result_ready (d8_in_result_ready),
      .out_quotient    (d8_out_quotient),
      .out_remainder   (d8_out_remainder),
      .out_busy        (d8_out_busy)
   );

   // Reference: plain arithmetic on sign/zero-extended 64-bit values, with
   // the two defined special cases handled first.
   function automatic void model(input int w, input bit s,
                                 input logic [63:0] a_in, input logic [63:0] b_in,
                                 output logic [63:0] q, output logic [63:0] r);
      logic [63:0] mask;
      logic [63:0] minv;
      logic [63:0] a;
      logic [63:0] b;
      longint      sa;
      longint      sb;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      minv = 64'd1 << (w - 1);
      a = a_in & mask;
      b = b_in & mask;
      if (b == 64'd0) begin
         q = mask;
         r = a;
      end else if (s && a == minv && b == mask) begin
         q = minv;
         r = 64'd0;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = longint'(a[w-1] ? (a | ~mask) : a);
         sb = longint'(b[w-1] ? (b | ~mask) : b);
         q = 64'(sa / sb) & mask;
         r = 64'(sa % sb) & mask;
      end
   endfunction

   function automatic bit is_special(input int w, input bit s,
                                     input logic [63:0] a, input logic [63:0] b);
      logic [63:0] mask;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      return ((b & mask) == 64'd0) ||
             (s && ((a & mask) == (64'd1 << (w - 1))) && ((b & mask) == mask));
   endfunction

   // Issue one 64-bit operation, wait for the result, check it and release it.
   task automatic run_op64(input bit s, input logic [63:0] a, input logic [63:0] b,
                           input string name);
      logic [63:0] eq;
      logic [63:0] er;
      int          exp_lat;
      int          cyc;
      model(W, s, a, b, eq, er);
      exp_lat = is_special(W, s, a, b) ? 2 : W + 2;
      @(negedge clk);
      checks++;
      if (out_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before_issue: got %b want 1", name, out_ready);
      end
      in_valid = 1'b1; in_signed = s; in_dividend = a; in_divisor = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_signed = 1'($urandom);
      in_dividend = {$urandom, $urandom};
      in_divisor = {$urandom, $urandom};
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
      end
      checks++;
      if (out_quotient !== eq) begin
         errors++;
         $display("FAIL %s quotient: got %h want %h", name, out_quotient, eq);
      end
      checks++;
      if (out_remainder !== er) begin
         errors++;
         $display("FAIL %s remainder: got %h want %h", name, out_remainder, er);
      end
      $display("OP64 %s s=%0d a=%h b=%h q=%h r=%h lat=%0d", name, s, a, b,
               out_quotient, out_remainder, cyc);
      in_result_ready = 1'b1;
      @(posedge clk); #1;
      in_result_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s handoff: got valid=%b ready=%b busy=%b want 0 1 0",
                  name, out_valid, out_ready, out_busy);
      end
   endtask

   // Same transaction flow against the 8-bit instance.
   task automatic run_op8(input bit s, input logic [7:0] a, input logic [7:0] b,
                          input string name);
      logic [63:0] eq;
      logic [63:0] er;
      int          exp_lat;
      int          cyc;
      model(W8, s, {56'd0, a}, {56'd0, b}, eq, er);
      exp_lat = is_special(W8, s, {56'd0, a}, {56'd0, b}) ? 2 : W8 + 2;
      @(negedge clk);
      d8_in_valid = 1'b1; d8_in_signed = s; d8_in_dividend = a; d8_in_divisor = b;
      @(posedge clk); #1;
      d8_in_valid = 1'b0;
      d8_in_dividend = 8'($urandom);
      d8_in_divisor = 8'($urandom);
      cyc = 1;
      while (d8_out_valid !== 1'b1 && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc != exp_lat || d8_out_quotient !== eq[7:0] || d8_out_remainder !== er[7:0]) begin
         errors++;
         $display("FAIL %s w8: got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", name,
                  d8_out_quotient, d8_out_remainder, cyc, eq[7:0], er[7:0], exp_lat);
      end
      $display("OP8 %s s=%0d a=%h b=%h q=%h r=%h lat=%0d", name, s, a, b,
               d8_out_quotient, d8_out_remainder, cyc);
      d8_in_result_ready = 1'b1;
      @(posedge clk); #1;
      d8_in_result_ready = 1'b0;
      checks++;
      if (d8_out_valid !== 1'b0 || d8_out_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s w8_handoff: got valid=%b ready=%b want 0 1",
                  name, d8_out_valid, d8_out_ready);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_busy !== 1'b0 ||
          out_quotient !== '0 || out_remainder !== '0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b ready=%b busy=%b q=%h r=%h want 0 1 0 0 0",
                  out_valid, out_ready, out_busy, out_quotient, out_remainder);
      end
      checks++;
      if (d8_out_valid !== 1'b0 || d8_out_ready !== 1'b1 || d8_out_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state_w8: got valid=%b ready=%b busy=%b want 0 1 0",
                  d8_out_valid, d8_out_ready, d8_out_busy);
      end
      $display("RESET state checked");
   endtask

   task automatic test_directed();
      run_op64(1'b0, 64'd100, 64'd7, "u100_div_7");
      run_op64(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "s_neg7_div_2");
      run_op64(1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, "s7_div_neg2");
      run_op64(1'b0, 64'd5, 64'd0, "u5_div_0");
      run_op64(1'b1, 64'hFFFF_FFFF_FFFF_FFF3, 64'd0, "s_neg13_div_0");
      run_op64(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "s_min_div_neg1");
      run_op64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, "u_divisor_msb");
      run_op64(1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "u_min_over_ones");
   endtask

   task automatic test_random();
      logic [63:0] a;
      logic [63:0] b;
      bit          s;
      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom);
         a = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: b = 64'd0;
            1: b = 64'($urandom_range(1, 1000));
            2: b = 64'hFFFF_FFFF_FFFF_FFFF;
            3: b = {32'd0, $urandom};
            default: b = {$urandom, $urandom};
         endcase
         if ($urandom_range(0, 7) == 0) a = 64'h8000_0000_0000_0000;
         run_op64(s, a, b, $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] eq;
      logic [63:0] er;
      int          cyc;
      bit          hold_ok;
      model(W, 1'b1, 64'hFFFF_FFFF_FFFF_FC18, 64'd9, eq, er);
      @(negedge clk);
      in_valid = 1'b1; in_signed = 1'b1;
      in_dividend = 64'hFFFF_FFFF_FFFF_FC18; in_divisor = 64'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      hold_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_signed = 1'b0;
         in_dividend = {$urandom, $urandom}; in_divisor = 64'd3;
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_ready !== 1'b0 || out_busy !== 1'b1 ||
             out_quotient !== eq || out_remainder !== er) hold_ok = 1'b0;
      end
      in_valid = 1'b0;
      checks++;
      if (!hold_ok) begin
         errors++;
         $display("FAIL backpressure_hold: got valid=%b ready=%b q=%h r=%h want 1 0 %h %h",
                  out_valid, out_ready, out_quotient, out_remainder, eq, er);
      end
      in_result_ready = 1'b1;
      @(posedge clk); #1;
      in_result_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_quotient !== eq ||
          out_remainder !== er) begin
         errors++;
         $display("FAIL backpressure_release: got valid=%b ready=%b q=%h r=%h want 0 1 %h %h",
                  out_valid, out_ready, out_quotient, out_remainder, eq, er);
      end
      $display("BACKPRESSURE held 10 cycles q=%h r=%h", out_quotient, out_remainder);
      run_op64(1'b0, 64'd1000, 64'd31, "after_backpressure");
   endtask

   task automatic test_back_to_back();
      run_op64(1'b0, 64'd123456789, 64'd1000, "b2b_first");
      run_op64(1'b1, 64'hFFFF_FFFF_FFFF_0000, 64'd0, "b2b_special");
      run_op64(1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFF0, "b2b_third");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      in_valid = 1'b1; in_signed = 1'b0;
      in_dividend = 64'd999_999; in_divisor = 64'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      checks++;
      if (out_busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_run_state: got busy=%b valid=%b want 1 0", out_busy, out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_busy !== 1'b0 ||
          out_quotient !== '0 || out_remainder !== '0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b ready=%b busy=%b q=%h r=%h want 0 1 0 0 0",
                  out_valid, out_ready, out_busy, out_quotient, out_remainder);
      end
      $display("RESET asserted mid-run");
      @(negedge clk);
      rst_n = 1'b1;
      run_op64(1'b0, 64'd9, 64'd3, "post_reset_9_div_3");
   endtask

   task automatic test_width8();
      run_op8(1'b1, 8'h80, 8'hFF, "w8_min_div_neg1");
      run_op8(1'b0, 8'hFF, 8'h80, "w8_divisor_msb");
      run_op8(1'b0, 8'h2A, 8'h00, "w8_div_0");
      run_op8(1'b1, 8'hF9, 8'h02, "w8_neg7_div_2");
      for (int i = 0; i < 24; i++) begin
         run_op8(1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)),
                 $sformatf("w8_rand%0d", i));
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_width8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/snow64_seq_divider.md
Name: snow64_seq_divider

Overview:
- Multi-cycle radix-2 restoring integer divider for the Snow64 ALU. It is the sequential, inverse-direction companion to the combinational shifters and set-less-than units.
- Accepts a dividend/divisor pair under valid/ready, and iterates one quotient bit per clock using shift-left plus subtract/compare.
- Holds quotient and remainder under valid/ready until consumed.
- Sits beside the single-cycle ALU; the ALU controller stalls on it for divide and remainder ops.

Parameters:
- WIDTH__DATA_INOUT, 64, operand/result width; legal values 8, 16, 32, 64.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair offered.
- out_ready  output  1  divider can accept; high only in IDLE.
- in_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled on accept.
- in_dividend  input  WIDTH__DATA_INOUT  dividend; sampled on accept.
- in_divisor  input  WIDTH__DATA_INOUT  divisor; sampled on accept.
- out_valid  output  1  result available.
- in_result_ready  input  1  consumer takes result.
- out_quotient  output  WIDTH__DATA_INOUT  quotient.
- out_remainder  output  WIDTH__DATA_INOUT  remainder.
- out_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; out_valid=0, out_quotient=0, out_remainder=0, out_busy=0, out_ready=1; iteration counter=0.
- Accept when in_valid && out_ready at a posedge. Operands and in_signed are latched into internal registers. The input buses may then change freely.
- States:
  - IDLE: on accept, go to SPECIAL if divisor==0 or (signed && dividend==MIN && divisor==all-ones); otherwise go to RUN.
  - RUN: exactly WIDTH__DATA_INOUT cycles, counter counts down from WIDTH__DATA_INOUT to 1. Counter width is $clog2(WIDTH__DATA_INOUT)+1.
  - FIXUP: one cycle; applies signs, then go to DONE.
  - SPECIAL: one cycle; loads the fixed results, then go to DONE.
  - DONE: out_valid=1; outputs stable; on in_result_ready go to IDLE.
- Signed handling: at accept, record sign_q = sign(a) XOR sign(b) and sign_r = sign(a), and latch the magnitudes |a| and |b|. In FIXUP, negate the quotient if sign_q and negate the remainder if sign_r. Division truncates toward zero.
- RUN step, on each cycle:
  - {rem, quo} shifted left 1 bit.
  - trial = rem - divisor, computed in WIDTH+1 bits.
  - If trial is non-negative, rem = trial and quo LSB = 1; otherwise quo LSB = 0.
  - A WIDTH+1-bit remainder register is required so the unsigned case handles divisors with the MSB set.
- SPECIAL results:
  - Divide-by-zero: quotient = all ones, remainder = dividend, for signed and unsigned alike.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- Latency, from accept edge to first cycle with out_valid=1:
  - Normal path: WIDTH__DATA_INOUT+2 cycles (RUN then FIXUP).
  - Special path: 2 cycles.
- Back-to-back: out_ready rises only the cycle after the DONE->IDLE handoff. Minimum issue interval is latency+1.
- in_valid outside IDLE is ignored (out_ready=0); no buffering.
- out_valid falls on the edge where in_result_ready is sampled high in DONE.
- out_quotient and out_remainder hold their last values after DONE, until the next result load.
- Reset mid-operation: abort immediately to the reset state. No partial result is ever presented.
- in_result_ready while not in DONE has no effect.

Decomposition:
- Add to the shared ALU package (PkgSnow64Alu):
  - state enum: IDLE, RUN, FIXUP, SPECIAL, DONE.
  - width localparams/macros for 8/16/32/64.
  - MIN-value constant helper.
- One natural sub-module: snow64_div_step. It is combinational: shift, trial subtract, restore select, one bit per invocation. It is instantiated once, and its result is registered each RUN cycle.

Test Plan:
- Unsigned 100 / 7, in_signed=0 -> out_valid after 66 cycles; quotient 14, remainder 2.
- Signed -7 / 2 (0xFFFF_FFFF_FFFF_FFF9, 2) -> quotient -3 (0x...FFFD), remainder -1 (0x...FFFF). Signed 7 / -2 -> quotient -3, remainder 1.
- Unsigned 5 / 0 -> out_valid after 2 cycles; quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5. At WIDTH=8, signed 0x80 / 0xFF -> quotient 0x80, remainder 0x00.
- Unsigned 0xFFFF_FFFF_FFFF_FFFF / 0x8000_0000_0000_0000 -> quotient 1, remainder 0x7FFF_FFFF_FFFF_FFFF (exercises the divisor-MSB case).
- Back-pressure: hold in_result_ready=0 for 10 cycles in DONE -> out_valid and outputs stable, out_ready=0, new in_valid ignored. Then pulse in_result_ready -> IDLE next cycle and next operands accepted.
- Reset: assert rst_n low asynchronously at RUN cycle 20 -> all outputs return to reset values immediately. After release, 9 / 3 -> quotient 3, remainder 0, with no stale data.
